// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-I core: encodings, FSM/ALU enums and
// big-endian byte-lane helpers (lane 0 carries bits 31:24).
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_t;

  typedef logic [3:0][7:0] lanes_t;

  function automatic lanes_t pack_lanes(input logic [31:0] w);
    lanes_t l;
    l[0] = w[31:24];
    l[1] = w[23:16];
    l[2] = w[15:8];
    l[3] = w[7:0];
    return l;
  endfunction

  function automatic logic [31:0] unpack_lanes(input lanes_t l);
    return {l[0], l[1], l[2], l[3]};
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// Architectural register file: NREGS x 32, two asynchronous read ports, one
// synchronous write port; register 0 is never written and always reads zero.
module mips_mc_regfile #(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr1,
  output logic [31:0]   o_rdata1,
  input  logic [AW-1:0] i_raddr2,
  output logic [31:0]   o_rdata2
);

  logic [31:0] r_mem [NREGS];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? 32'h0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? 32'h0 : r_mem[i_raddr2];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-I core (FETCH/DECODE/EXEC/MEM/WB) with valid/ready memory handshakes
// and a stall watchdog. Optional performance counters: define MIPS_MC_PERF_EN.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16,
  parameter int          NREGS      = 32
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        mem_req,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output lanes_t      mem_data_in,
  input  lanes_t      mem_data_out,
  input  logic        mem_ready,
  output logic        halted,
  output logic        error,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_retired
);

  localparam int AW = $clog2(NREGS);

  state_t        r_state, w_next;
  logic [31:0]   r_pc, r_ir, r_a, r_b, r_aluout, r_mdr, r_wait;
  logic          r_error, w_err_set;
  logic [31:0]   w_pc4, w_imm_s, w_imm_z, w_opb, w_alu, w_rd1, w_rd2, w_pc_next;
  logic [5:0]    w_op, w_fn;
  logic          w_is_r, w_legal, w_syscall, w_stall, w_trip, w_taken, w_pc_we;
  alu_op_t       w_alu_op;

  assign w_op    = r_ir[31:26];
  assign w_fn    = r_ir[5:0];
  assign w_is_r  = (w_op == OP_RTYPE);
  assign w_pc4   = r_pc + 32'd4;
  assign w_imm_s = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_imm_z = {16'h0, r_ir[15:0]};
  assign w_taken = (r_a == r_b) ^ (w_op == OP_BNE);

  always_comb begin
    w_legal   = 1'b1;
    w_syscall = 1'b0;
    w_alu_op  = ALU_ADD;
    if (w_is_r) begin
      unique case (w_fn)
        FN_ADD, FN_ADDU: w_alu_op = ALU_ADD;
        FN_SUB, FN_SUBU: w_alu_op = ALU_SUB;
        FN_AND:          w_alu_op = ALU_AND;
        FN_OR:           w_alu_op = ALU_OR;
        FN_SLT:          w_alu_op = ALU_SLT;
        FN_SYSCALL:      w_syscall = 1'b1;
        default:         w_legal = 1'b0;
      endcase
    end else begin
      unique case (w_op)
        OP_J, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: w_alu_op = ALU_ADD;
        OP_BEQ, OP_BNE: w_alu_op = ALU_SUB;
        OP_SLTI:        w_alu_op = ALU_SLT;
        OP_ANDI:        w_alu_op = ALU_AND;
        OP_ORI:         w_alu_op = ALU_OR;
        OP_LUI:         w_alu_op = ALU_LUI;
        default:        w_legal = 1'b0;
      endcase
    end
  end

  // andi/ori take a zero-extended immediate, every other I-type sign-extends
  assign w_opb = w_is_r ? r_b : ((w_op == OP_ANDI) || (w_op == OP_ORI)) ? w_imm_z : w_imm_s;

  always_comb begin
    w_alu = 32'h0;
    unique case (w_alu_op)
      ALU_ADD: w_alu = r_a + w_opb;
      ALU_SUB: w_alu = r_a - w_opb;
      ALU_AND: w_alu = r_a & w_opb;
      ALU_OR:  w_alu = r_a | w_opb;
      ALU_SLT: w_alu = {31'h0, ($signed(r_a) < $signed(w_opb))};
      ALU_LUI: w_alu = {r_ir[15:0], 16'h0};
      default: w_alu = 32'h0;
    endcase
  end

  assign w_stall = ((r_state == FETCH) && !inst_valid) || ((r_state == MEM) && !mem_ready);
  assign w_trip  = (WAIT_LIMIT != 0) && w_stall && (r_wait == 32'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    unique case (r_state)
      FETCH: begin
        if (inst_valid) w_next = DECODE;
        else if (w_trip) begin w_next = HALT; w_err_set = 1'b1; end
      end
      DECODE: begin
        if (!w_legal) begin w_next = HALT; w_err_set = 1'b1; end
        else if (w_op == OP_J) w_next = FETCH;
        else if (w_syscall)    w_next = HALT;
        else                   w_next = EXEC;
      end
      EXEC: begin
        if ((w_op == OP_BEQ) || (w_op == OP_BNE))    w_next = FETCH;
        else if ((w_op == OP_LW) || (w_op == OP_SW)) w_next = MEM;
        else                                         w_next = WB;
      end
      MEM: begin
        if (mem_ready) w_next = (w_op == OP_LW) ? WB : FETCH;
        else if (w_trip) begin w_next = HALT; w_err_set = 1'b1; end
      end
      WB:      w_next = FETCH;
      default: w_next = HALT;
    endcase
  end

  always_comb begin
    inst_req     = rst_b && (r_state == FETCH);
    inst_addr    = r_pc;
    mem_req      = (r_state == MEM);
    mem_write_en = (r_state == MEM) && (w_op == OP_SW);
    mem_addr     = r_aluout;
    mem_data_in  = pack_lanes(r_b);
    halted       = (r_state == HALT);
    error        = r_error;
  end

  // PC only moves when an instruction finishes and control returns to FETCH
  assign w_pc_we = (w_next == FETCH) && (r_state != FETCH);
  always_comb begin
    if (r_state == DECODE)                w_pc_next = {w_pc4[31:28], r_ir[25:0], 2'b00};
    else if ((r_state == EXEC) && w_taken) w_pc_next = w_pc4 + (w_imm_s << 2);
    else                                  w_pc_next = w_pc4;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pc    <= RESET_PC;
      r_error <= 1'b0;
      r_wait  <= 32'h0;
    end else begin
      if (w_pc_we)   r_pc <= w_pc_next;
      if (w_err_set) r_error <= 1'b1;
      r_wait <= w_stall ? (r_wait + 32'd1) : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == FETCH) && inst_valid) r_ir <= inst;
    if (r_state == DECODE) begin
      r_a <= w_rd1;
      r_b <= w_rd2;
    end
    if (r_state == EXEC) r_aluout <= w_alu;
    if ((r_state == MEM) && mem_ready) r_mdr <= unpack_lanes(mem_data_out);
  end

  mips_mc_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_b    (rst_b),
    .i_we     (r_state == WB),
    .i_waddr  (w_is_r ? r_ir[11 +: AW] : r_ir[16 +: AW]),
    .i_wdata  ((w_op == OP_LW) ? r_mdr : r_aluout),
    .i_raddr1 (r_ir[21 +: AW]),
    .o_rdata1 (w_rd1),
    .i_raddr2 (r_ir[16 +: AW]),
    .o_rdata2 (w_rd2)
  );

`ifdef MIPS_MC_PERF_EN
  logic [31:0] r_cycles, r_retired;
  logic        w_retire;

  // error halts never count as a retirement; syscall does
  assign w_retire = ((w_next == FETCH) && (r_state != FETCH)) ||
                    ((r_state == DECODE) && w_legal && w_syscall);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cycles  <= 32'h0;
      r_retired <= 32'h0;
    end else begin
      if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
      if (w_retire) r_retired <= r_retired + 32'd1;
    end
  end

  assign perf_cycles  = r_cycles;
  assign perf_retired = r_retired;
`else
  assign perf_cycles  = 32'h0;
  assign perf_retired = 32'h0;
`endif

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core with combinational instruction memory and a
// byte-lane data memory whose ready latency is programmable per test.
module tb_mips_mc_core;
  import mips_mc_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        inst_req, inst_valid;
  logic [31:0] inst_addr, inst;
  logic        mem_req, mem_write_en, mem_ready;
  logic [31:0] mem_addr;
  lanes_t      mem_data_in, mem_data_out;
  logic        halted, error;
  logic [31:0] perf_cycles, perf_retired;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic        block_inst = 1'b0;
  logic        clr_mem = 1'b0;
  int          mem_lat = 0;
  int          mem_cnt = 0;
  int          n_writes = 0;
  lanes_t      last_lanes;
  logic [31:0] last_waddr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mips_mc_core #(.RESET_PC(RESET_PC), .WAIT_LIMIT(16), .NREGS(32)) dut (
    .clk(clk), .rst_b(rst_b),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid), .inst(inst),
    .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready),
    .halted(halted), .error(error), .perf_cycles(perf_cycles), .perf_retired(perf_retired)
  );

  assign inst_valid   = inst_req && !block_inst;
  assign inst         = imem[inst_addr[7:2]];
  assign mem_data_out = pack_lanes(dmem[mem_addr[7:2]]);
  assign mem_ready    = mem_req && (mem_cnt == mem_lat);

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
      n_writes <= 0;
      mem_cnt  <= 0;
    end else begin
      if (mem_req && !mem_ready) mem_cnt <= mem_cnt + 1;
      else                       mem_cnt <= 0;
      if (mem_req && mem_ready && mem_write_en) begin
        dmem[mem_addr[7:2]] <= unpack_lanes(mem_data_in);
        n_writes   <= n_writes + 1;
        last_lanes <= mem_data_in;
        last_waddr <= mem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_000C;
  endtask

  task automatic hold_reset();
    rst_b = 1'b0; block_inst = 1'b0; clr_mem = 1'b1;
    @(posedge clk); #1;
    clr_mem = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_alu_prog();
    clear_imem();
    imem[0] = 32'h2001_0005;
    imem[1] = 32'h2002_FFFD;
    imem[2] = 32'h0022_1820;
    imem[3] = 32'h0000_000C;
  endtask

  task automatic test_reset();
    load_alu_prog();
    hold_reset();
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL rst_inst_req got=%b want=0", inst_req); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_write_en); end
    total++; if (halted !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_halt got=%b%b want=00", halted, error); end
    total++; if (inst_addr !== RESET_PC) begin bad++; $display("FAIL rst_pc got=%h want=%h", inst_addr, RESET_PC); end
    total++; if (perf_cycles !== 32'h0 || perf_retired !== 32'h0) begin bad++; $display("FAIL rst_perf got=%h/%h want=0/0", perf_cycles, perf_retired); end
    rst_b = 1'b1;
    #1;
    total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL rel_inst_req got=%b want=1", inst_req); end
  endtask

  task automatic test_alu_program();
    load_alu_prog();
    hold_reset();
    rst_b = 1'b1;
    repeat (13) tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL alu_early_halt got=%b want=0", halted); end
    tick();
    total++; if (halted !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL alu_halt got=%b%b want=10", halted, error); end
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL alu_req_in_halt got=%b want=0", inst_req); end
    total++; if (dut.u_regfile.r_mem[1] !== 32'd5) begin bad++; $display("FAIL alu_r1 got=%h want=5", dut.u_regfile.r_mem[1]); end
    total++; if (dut.u_regfile.r_mem[2] !== 32'hFFFF_FFFD) begin bad++; $display("FAIL alu_r2 got=%h want=fffffffd", dut.u_regfile.r_mem[2]); end
    total++; if (dut.u_regfile.r_mem[3] !== 32'd2) begin bad++; $display("FAIL alu_r3 got=%h want=2", dut.u_regfile.r_mem[3]); end
  endtask

  task automatic test_store_load();
    int e4, e8, e12;
    e4 = -1; e8 = -1; e12 = -1;
    clear_imem();
    imem[0] = 32'h2003_0002;
    imem[1] = 32'hAC03_0008;
    imem[2] = 32'h8C04_0008;
    imem[3] = 32'h0000_000C;
    mem_lat = 3;
    hold_reset();
    rst_b = 1'b1;
    for (int e = 1; e <= 40 && !halted; e++) begin
      tick();
      if (inst_req && inst_addr == 32'h4 && e4 < 0) e4 = e;
      if (inst_req && inst_addr == 32'h8 && e8 < 0) e8 = e;
      if (inst_req && inst_addr == 32'hC && e12 < 0) e12 = e;
    end
    total++; if (halted !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL sl_timeout halted/error got=%b%b want=10", halted, error); end
    total++; if (n_writes !== 1) begin bad++; $display("FAIL sl_nwrites got=%0d want=1", n_writes); end
    total++; if (last_waddr !== 32'h8) begin bad++; $display("FAIL sl_waddr got=%h want=8", last_waddr); end
    total++; if (last_lanes[3] !== 8'h02 || last_lanes[0] !== 8'h00) begin bad++; $display("FAIL sl_lanes got=%h want=00000002", last_lanes); end
    total++; if (e8 - e4 !== 7) begin bad++; $display("FAIL sl_sw_cycles got=%0d want=7", e8 - e4); end
    total++; if (e12 - e8 !== 8) begin bad++; $display("FAIL sl_lw_cycles got=%0d want=8", e12 - e8); end
    total++; if (dut.u_regfile.r_mem[4] !== 32'd2) begin bad++; $display("FAIL sl_r4 got=%h want=2", dut.u_regfile.r_mem[4]); end
    total++; if (dmem[2] !== 32'd2) begin bad++; $display("FAIL sl_dmem got=%h want=2", dmem[2]); end
    mem_lat = 0;
  endtask

  task automatic test_watchdog();
    clear_imem();
    imem[0] = 32'h1000_FFFF;
    hold_reset();
    rst_b = 1'b1;
    repeat (12) tick();
    total++; if (inst_req !== 1'b1 || inst_addr !== 32'h0 || halted !== 1'b0) begin bad++; $display("FAIL wd_loop got req=%b pc=%h halt=%b want 1/0/0", inst_req, inst_addr, halted); end
    block_inst = 1'b1;
    repeat (15) tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL wd_early got=%b want=0", halted); end
    tick();
    total++; if (halted !== 1'b1 || error !== 1'b1) begin bad++; $display("FAIL wd_trip got=%b%b want=11", halted, error); end
    total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL wd_req got=%b want=0", inst_req); end
    block_inst = 1'b0;
    repeat (3) tick();
    total++; if (halted !== 1'b1 || inst_addr !== 32'h0) begin bad++; $display("FAIL wd_absorb got halt=%b pc=%h want 1/0", halted, inst_addr); end
  endtask

  task automatic test_illegal();
    clear_imem();
    imem[0] = 32'h2001_0007;
    imem[1] = 32'hFC00_0000;
    hold_reset();
    rst_b = 1'b1;
    repeat (5) tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL ill_early got=%b want=0", halted); end
    tick();
    total++; if (halted !== 1'b1 || error !== 1'b1) begin bad++; $display("FAIL ill_halt got=%b%b want=11", halted, error); end
    total++; if (inst_addr !== 32'h4) begin bad++; $display("FAIL ill_pc got=%h want=4", inst_addr); end
    total++; if (dut.u_regfile.r_mem[1] !== 32'd7) begin bad++; $display("FAIL ill_r1 got=%h want=7", dut.u_regfile.r_mem[1]); end
  endtask

  task automatic test_reset_mid_store();
    clear_imem();
    imem[0] = 32'h2003_0055;
    imem[1] = 32'hAC03_0010;
    mem_lat = 10;
    hold_reset();
    rst_b = 1'b1;
    repeat (7) tick();
    total++; if (mem_req !== 1'b1 || mem_write_en !== 1'b1) begin bad++; $display("FAIL rms_setup got=%b%b want=11", mem_req, mem_write_en); end
    #2;
    rst_b = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rms_req got=%b want=0", mem_req); end
    total++; if (inst_addr !== RESET_PC || inst_req !== 1'b0) begin bad++; $display("FAIL rms_pc got=%h req=%b want=%h/0", inst_addr, inst_req, RESET_PC); end
    repeat (3) tick();
    total++; if (n_writes !== 0 || dmem[4] !== 32'h0) begin bad++; $display("FAIL rms_write got n=%0d d=%h want 0/0", n_writes, dmem[4]); end
    mem_lat = 0;
  endtask

  task automatic test_branch_jump();
    clear_imem();
    imem[0]  = 32'h0800_0004;
    imem[1]  = 32'h2005_0001;
    imem[2]  = 32'h2005_0001;
    imem[3]  = 32'h2005_0001;
    imem[4]  = 32'h1400_0005;
    imem[5]  = 32'h3406_FFFF;
    imem[6]  = 32'h3C07_8000;
    imem[7]  = 32'h00E6_402A;
    imem[8]  = 32'h0006_4822;
    imem[9]  = 32'h312A_8001;
    imem[10] = 32'h2000_0009;
    imem[11] = 32'h0000_000C;
    hold_reset();
    rst_b = 1'b1;
    repeat (30) tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL bj_early got=%b want=0", halted); end
    tick();
    total++; if (halted !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL bj_halt got=%b%b want=10", halted, error); end
    total++; if (dut.u_regfile.r_mem[5] !== 32'h0) begin bad++; $display("FAIL bj_skip got=%h want=0", dut.u_regfile.r_mem[5]); end
    total++; if (dut.u_regfile.r_mem[6] !== 32'h0000_FFFF) begin bad++; $display("FAIL bj_ori got=%h want=0000ffff", dut.u_regfile.r_mem[6]); end
    total++; if (dut.u_regfile.r_mem[7] !== 32'h8000_0000) begin bad++; $display("FAIL bj_lui got=%h want=80000000", dut.u_regfile.r_mem[7]); end
    total++; if (dut.u_regfile.r_mem[8] !== 32'h1) begin bad++; $display("FAIL bj_slt got=%h want=1", dut.u_regfile.r_mem[8]); end
    total++; if (dut.u_regfile.r_mem[9] !== 32'hFFFF_0001) begin bad++; $display("FAIL bj_sub got=%h want=ffff0001", dut.u_regfile.r_mem[9]); end
    total++; if (dut.u_regfile.r_mem[10] !== 32'h1) begin bad++; $display("FAIL bj_andi got=%h want=1", dut.u_regfile.r_mem[10]); end
    total++; if (dut.u_regfile.r_mem[0] !== 32'h0) begin bad++; $display("FAIL bj_r0 got=%h want=0", dut.u_regfile.r_mem[0]); end
  endtask

  task automatic test_perf();
    load_alu_prog();
    hold_reset();
    rst_b = 1'b1;
    repeat (14) tick();
`ifdef MIPS_MC_PERF_EN
    total++; if (perf_retired !== 32'd4) begin bad++; $display("FAIL perf_retired got=%0d want=4", perf_retired); end
    total++; if (perf_cycles !== 32'd14) begin bad++; $display("FAIL perf_cycles got=%0d want=14", perf_cycles); end
    repeat (5) tick();
    total++; if (perf_cycles !== 32'd19 || perf_retired !== 32'd4) begin bad++; $display("FAIL perf_after_halt got=%0d/%0d want=19/4", perf_cycles, perf_retired); end
`else
    total++; if (perf_retired !== 32'd0 || perf_cycles !== 32'd0) begin bad++; $display("FAIL perf_off got=%0d/%0d want=0/0", perf_cycles, perf_retired); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_program();
    test_store_load();
    test_watchdog();
    test_illegal();
    test_reset_mid_store();
    test_branch_jump();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
